// File: rtl/phase_controller_pkg.sv
// Shared types for the traffic-signal phase controller: lamp encodings and FSM states.
package tl_pkg;

  typedef enum logic [1:0] {
    L_OFF    = 2'b00,
    L_GREEN  = 2'b01,
    L_YELLOW = 2'b10,
    L_RED    = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    S_FLASH,
    S_ALLRED,
    S_GREEN,
    S_YELLOW
  } ctl_state_t;

endpackage

// File: rtl/phase_controller_if.sv
// Sensor/lamp bundle between the intersection sensors, the controller and the lamp drivers.
interface phase_controller_if #(
  parameter int NPHASE = 3,
  parameter int CW     = 8
);
  localparam int PW = $clog2(NPHASE);

  logic [NPHASE-1:0]    sensor;
  logic [NPHASE*CW-1:0] max_green;
  logic                 flash_req;
  logic [2*NPHASE-1:0]  light;
  logic [PW-1:0]        active_phase;
  logic                 phase_done;

  modport master (
    output sensor, max_green, flash_req,
    input  light, active_phase, phase_done
  );

  modport slave (
    input  sensor, max_green, flash_req,
    output light, active_phase, phase_done
  );
endinterface

// File: rtl/phase_controller_arbiter.sv
// Rotating-priority demand arbiter: picks the first waiting phase after cur, wrapping around.
module phase_arbiter #(
  parameter int NPHASE = 3,
  parameter int PW     = $clog2(NPHASE)
) (
  input  logic [NPHASE-1:0] sensor_i,
  input  logic [PW-1:0]     cur_i,
  output logic [PW-1:0]     next_phase_o,
  output logic              other_demand_o
);

  localparam logic [PW:0] NP_W = (PW+1)'(NPHASE);

  logic [PW:0] idx;

  // Scan from the farthest candidate down so the nearest waiting phase is the last to win.
  always_comb begin
    // NOTE: every output gets a default before any conditional assignment, otherwise a latch is inferred.
    next_phase_o   = cur_i;
    other_demand_o = 1'b0;
    idx            = '0;
    for (int k = NPHASE - 1; k >= 1; k--) begin
      idx = {1'b0, cur_i} + (PW+1)'(k);
      if (idx >= NP_W) idx = idx - NP_W;
      if (sensor_i[idx[PW-1:0]]) begin
        next_phase_o   = idx[PW-1:0];
        other_demand_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_controller.sv
// Sensor-actuated signal controller: FLASH -> ALLRED -> GREEN -> YELLOW cycling over NPHASE
// mutually exclusive phases with min/max green, gap-out, round-robin service and flash override.
module phase_controller
  import tl_pkg::*;
#(
  parameter int NPHASE    = 3,
  parameter int CW        = 8,
  parameter int MIN_GREEN = 5,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int FLASH_T   = 2
) (
  input  logic             Clock,
  input  logic             reset,
  phase_controller_if.slave bus
);

  localparam int PW = $clog2(NPHASE);
  localparam int TW = CW + 1;

  localparam logic [TW-1:0] MIN_W    = TW'(MIN_GREEN);
  localparam logic [TW-1:0] YELLOW_W = TW'(YELLOW_T);
  localparam logic [TW-1:0] ALLRED_W = TW'(ALLRED_T);
  localparam logic [TW-1:0] FLASH_W  = TW'(FLASH_T);

  ctl_state_t    state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] next_q, next_d;
  logic          done_q, done_d;

  logic [CW-1:0] mg [NPHASE];
  logic [PW-1:0] arb_next;
  logic          other;
  logic [TW-1:0] timer_inc;
  logic [TW-1:0] eff_max;
  logic          max_out;
  logic          gap_out;
  light_t        lamp [NPHASE];

  for (genvar p = 0; p < NPHASE; p++) begin : g_field
    assign mg[p]                 = bus.max_green[p*CW +: CW];
    assign bus.light[2*p +: 2]   = lamp[p];
  end

  phase_arbiter #(
    .NPHASE (NPHASE),
    .PW     (PW)
  ) u_arb (
    .sensor_i       (bus.sensor),
    .cur_i          (cur_q),
    .next_phase_o   (arb_next),
    .other_demand_o (other)
  );

  // timer_inc is "cycles spent once this cycle completes"; one bit wider so it never wraps.
  always_comb begin
    timer_inc = {1'b0, timer_q} + TW'(1);
    eff_max   = ({1'b0, mg[cur_q]} > MIN_W) ? {1'b0, mg[cur_q]} : MIN_W;
    max_out   = timer_inc >= eff_max;
    gap_out   = (timer_inc >= MIN_W) && !bus.sensor[cur_q];
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    next_d  = next_q;
    done_d  = 1'b0;
    timer_d = (&timer_q) ? timer_q : timer_q + CW'(1);

    if (bus.flash_req) begin
      state_d = S_FLASH;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_FLASH: begin
          if (timer_inc >= FLASH_W) begin
            cur_d   = '0;
            next_d  = '0;
            timer_d = '0;
            state_d = (ALLRED_T == 0) ? S_GREEN : S_ALLRED;
          end
        end
        S_ALLRED: begin
          if (timer_inc >= ALLRED_W) begin
            state_d = S_GREEN;
            cur_d   = next_q;
            timer_d = '0;
          end
        end
        S_GREEN: begin
          if (other && (max_out || gap_out)) begin
            state_d = S_YELLOW;
            next_d  = arb_next;
            timer_d = '0;
          end
        end
        S_YELLOW: begin
          if (timer_inc >= YELLOW_W) begin
            done_d  = 1'b1;
            timer_d = '0;
            if (ALLRED_T == 0) begin
              state_d = S_GREEN;
              cur_d   = next_q;
            end else begin
              state_d = S_ALLRED;
            end
          end
        end
        default: state_d = S_FLASH;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FLASH;
      timer_q <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q <= state_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      done_q  <= done_d;
    end
  end

  // Lamps are a pure decode of state_q/cur_q, so they glitch only when those registers change.
  always_comb begin
    for (int p = 0; p < NPHASE; p++) begin
      lamp[p] = L_RED;
      if (state_q == S_FLASH) begin
        lamp[p] = L_OFF;
      end else if (cur_q == PW'(p)) begin
        if (state_q == S_GREEN)  lamp[p] = L_GREEN;
        if (state_q == S_YELLOW) lamp[p] = L_YELLOW;
      end
    end
  end

  assign bus.active_phase = (state_q == S_FLASH) ? '0 : cur_q;
  assign bus.phase_done   = done_q;

endmodule

// File: tb/tb_phase_controller.sv
// Directed bench for phase_controller: reset/rest, gap-out, max-out, round robin, flash, async reset.
module tb_phase_controller;

  localparam int NPHASE = 3;
  localparam int CW     = 8;

  localparam logic [5:0] OFF = 6'b000000;
  localparam logic [5:0] RED = 6'b111111;
  localparam logic [5:0] G0  = 6'b111101;
  localparam logic [5:0] Y0  = 6'b111110;
  localparam logic [5:0] G1  = 6'b110111;
  localparam logic [5:0] Y1  = 6'b111011;
  localparam logic [5:0] G2  = 6'b011111;
  localparam logic [5:0] Y2  = 6'b101111;

  logic Clock = 1'b0;
  logic reset = 1'b0;

  always #5 Clock = ~Clock;

  phase_controller_if #(.NPHASE(NPHASE), .CW(CW)) bus ();

  phase_controller #(
    .NPHASE    (NPHASE),
    .CW        (CW),
    .MIN_GREEN (5),
    .YELLOW_T  (3),
    .ALLRED_T  (1),
    .FLASH_T   (2)
  ) dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always @(negedge Clock) if (bus.phase_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic measure(input logic [5:0] pat, output int n);
    n = 0;
    while (bus.light === pat && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_for(input string tag, input logic [5:0] pat);
    int n = 0;
    while (bus.light !== pat && n < 300) begin
      n++;
      tick();
    end
    check(tag, 32'(bus.light), 32'(pat));
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.sensor    = '0;
    bus.flash_req = 1'b0;
    tick();
    tick();
    check("rst_light", 32'(bus.light), 32'(OFF));
    check("rst_active", 32'(bus.active_phase), 32'd0);
    check("rst_done", 32'(bus.phase_done), 32'd0);
    reset = 1'b1;
  endtask

  logic [5:0] rr_pat [9];
  int         rr_len [9];
  int         n;
  int         d0;
  int         g0_cycles;

  initial begin
    bus.max_green = {8'd10, 8'd20, 8'd44};
    rr_pat = '{G0, Y0, RED, G1, Y1, RED, G2, Y2, RED};
    rr_len = '{44, 3, 1, 20, 3, 1, 10, 3, 1};

    // Reset with no demand: 2 flash, 1 all-red, then phase 0 rests in green.
    do_reset();
    d0 = done_cnt;
    measure(OFF, n);  check("idle_flash_len", 32'(n), 32'd2);
    measure(RED, n);  check("idle_allred_len", 32'(n), 32'd1);
    check("idle_green0", 32'(bus.light), 32'(G0));
    g0_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.light === G0) g0_cycles++;
      tick();
    end
    check("idle_rest_len", 32'(g0_cycles), 32'd60);
    check("idle_no_done", 32'(done_cnt - d0), 32'd0);

    // Gap-out: phase 0 loses demand, phase 1 calls from green cycle 0.
    do_reset();
    wait_for("gap_reach_g0", G0);
    bus.sensor = 3'b010;
    d0 = done_cnt;
    measure(G0, n);   check("gap_green_len", 32'(n), 32'd5);
    check("gap_yel_active", 32'(bus.active_phase), 32'd0);
    measure(Y0, n);   check("gap_yellow_len", 32'(n), 32'd3);
    check("gap_done_pulse", 32'(bus.phase_done), 32'd1);
    measure(RED, n);  check("gap_allred_len", 32'(n), 32'd1);
    check("gap_green1", 32'(bus.light), 32'(G1));
    check("gap_active1", 32'(bus.active_phase), 32'd1);
    check("gap_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Max-out: phase 0 keeps demand, phase 2 calls; phase 1 idle is skipped.
    do_reset();
    wait_for("max_reach_g0", G0);
    bus.sensor = 3'b101;
    measure(G0, n);   check("max_green0_len", 32'(n), 32'd44);
    measure(Y0, n);   check("max_yellow0_len", 32'(n), 32'd3);
    check("max_allred_active", 32'(bus.active_phase), 32'd0);
    measure(RED, n);  check("max_allred_len", 32'(n), 32'd1);
    check("max_green2", 32'(bus.light), 32'(G2));
    check("max_active2", 32'(bus.active_phase), 32'd2);
    measure(G2, n);   check("max_green2_len", 32'(n), 32'd10);
    measure(Y2, n);   check("max_yellow2_len", 32'(n), 32'd3);
    measure(RED, n);  check("max_allred2_len", 32'(n), 32'd1);
    check("max_back_g0", 32'(bus.light), 32'(G0));

    // Round robin with every phase calling: 0,1,2 then wrap to 0.
    do_reset();
    wait_for("rr_reach_g0", G0);
    bus.sensor = 3'b111;
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) begin
      measure(rr_pat[i], n);
      check($sformatf("rr_len_%0d", i), 32'(n), 32'(rr_len[i]));
    end
    check("rr_wrap_g0", 32'(bus.light), 32'(G0));
    check("rr_done_cnt", 32'(done_cnt - d0), 32'd3);

    // Flash request mid-yellow: no clearance, 2 flash cycles after release.
    measure(G0, n);   check("fl_green0_len", 32'(n), 32'd44);
    tick();
    check("fl_mid_yellow", 32'(bus.light), 32'(Y0));
    d0 = done_cnt;
    bus.flash_req = 1'b1;
    tick();
    check("fl_off_next_edge", 32'(bus.light), 32'(OFF));
    check("fl_active0", 32'(bus.active_phase), 32'd0);
    repeat (3) tick();
    check("fl_held", 32'(bus.light), 32'(OFF));
    bus.flash_req = 1'b0;
    measure(OFF, n);  check("fl_release_len", 32'(n), 32'd2);
    measure(RED, n);  check("fl_allred_len", 32'(n), 32'd1);
    check("fl_restart_g0", 32'(bus.light), 32'(G0));
    check("fl_no_done", 32'(done_cnt - d0), 32'd0);

    // Asynchronous reset while phase 1 is green.
    measure(G0, n);
    measure(Y0, n);
    measure(RED, n);
    check("ar_green1", 32'(bus.light), 32'(G1));
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check("ar_async_off", 32'(bus.light), 32'(OFF));
    check("ar_async_active", 32'(bus.active_phase), 32'd0);
    check("ar_async_done", 32'(bus.phase_done), 32'd0);
    bus.sensor = '0;
    tick();
    reset = 1'b1;
    measure(OFF, n);  check("ar_flash_len", 32'(n), 32'd2);
    measure(RED, n);  check("ar_allred_len", 32'(n), 32'd1);
    check("ar_restart_g0", 32'(bus.light), 32'(G0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
